cycle_sequencer: RTL
====================

Name: cycle_sequencer

Overview:
- Multi-cycle instruction sequencer for the g2 CPU core.
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the instruction/data memory request handshakes and issues the one-cycle write_pc/write_reg/write_lr strobes that commit architectural state.
- Sits beside the opcode/funct decoder (which still supplies alu_func/cp_type); owns timing only.

Parameters:
- TIMEOUT, 64, max cycles a memory request may wait for ack before FAULT; 0 disables the watchdog.
- HALT_OP, 6'b111110, opecode that stops the sequencer.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- opecode  in  6  opcode field of instruction register (valid from DECODE onward).
- funct  in  6  funct field of instruction register.
- imem_req  out  1  instruction fetch request, held until ack.
- imem_ack  in  1  fetch data valid this cycle.
- ir_load  out  1  load instruction register (= FETCH & imem_ack).
- dmem_req  out  1  data memory request, held until ack.
- dmem_we  out  1  store (1) / load (0), valid while dmem_req.
- dmem_ack  in  1  data access complete this cycle.
- write_pc  out  1  commit next PC; exactly one pulse per retired instruction.
- write_reg  out  1  register file write strobe.
- write_lr  out  1  link register write strobe.
- halted  out  1  sticky, HALT state.
- fault  out  1  sticky, memory watchdog expired.
- state_dbg  out  3  current state encoding.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: state=FETCH, wait_cnt=0, retired=0. While rst=1 every strobe/request output forced 0; halted=fault=0.
- All outputs are combinational decodes of state plus acks; no output registers.
- Instruction classes (from opecode/funct):
  - LOAD 100011.
  - STORE 101011.
  - CTRL: 000010 j, 000011 jal, 000100 beq, 000101 bne, 000000 with funct 001000 jr, 111111.
  - ALU: 000000 other funct, 001000, 001100, 001101, 001010.
  - HALT: HALT_OP.
  - anything else NOP.
- FETCH(0): imem_req=1. On imem_ack: ir_load=1, go DECODE. Otherwise stay.
- DECODE(1): one cycle, no strobes, go EXEC.
- EXEC(2):
  - CTRL: write_pc=1; write_lr=1 additionally for jal; then FETCH.
  - NOP: write_pc=1, then FETCH.
  - LOAD/STORE: go MEM.
  - ALU: go WB.
  - HALT: go HALT, no write_pc.
- MEM(3): dmem_req=1, dmem_we=(STORE). On dmem_ack:
  - STORE: write_pc=1 same cycle, then FETCH.
  - LOAD: go WB.
- WB(4): write_reg=1 and write_pc=1 for one cycle, then FETCH.
- Instruction latency with zero-wait memory: CTRL/NOP 3 cycles, ALU 4, STORE 4, LOAD 5. Each wait cycle adds one.
- HALT(5): all strobes 0, halted=1; exits only on rst.
- FAULT(6): all strobes 0, fault=1; exits only on rst.
- Watchdog: wait_cnt clears on entering FETCH/MEM and on any ack. Increments each cycle req is high without ack. When TIMEOUT!=0 and wait_cnt==TIMEOUT-1 with no ack that cycle, go FAULT. An ack in that same cycle wins.
- retired increments on each write_pc pulse; wraps modulo 2^CNT_W.
- Acks outside the matching request state are ignored; no spurious strobes.
- rst mid-instruction aborts immediately. No partial strobe is emitted after rst deasserts; restarts at FETCH.
- opecode/funct must be stable DECODE through end of instruction; the sequencer does not latch them.

Decomposition:
- cpu_pkg: opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_JR_FUNCT), 3-bit state encodings, class encodings.
- Sub-module op_classifier: pure combinational opecode/funct -> class. Shareable with the existing decoder.

Test Plan:
- ALU add (op 0, funct 100000), imem_ack immediate -> ir_load c0, write_reg+write_pc c3, back in FETCH c4, retired=1.
- lw with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, write_reg+write_pc one cycle after ack, total 8 cycles.
- sw, immediate ack -> dmem_we=1, write_pc on ack cycle, write_reg never asserted.
- jal -> write_pc and write_lr in same cycle (EXEC, c2); write_reg 0; then fetch.
- TIMEOUT=4, imem_ack never -> fault=1 after cycle 4, all strobes 0 thereafter; TIMEOUT=4 with ack on 4th wait cycle -> no fault.
- HALT_OP fetched -> halted=1, no write_pc, retired unchanged. rst pulse mid-MEM -> outputs 0 immediately, FETCH after release, retired=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the g2 core control path: opcodes, sequencer states
// and the instruction classes the sequencer cares about.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SW       = 6'b101011;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_JAL      = 6'b000011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_CTRL_X   = 6'b111111;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_ANDI     = 6'b001100;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_SLTI     = 6'b001010;
  localparam logic [5:0] OP_JR_FUNCT = 6'b001000;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP   = 3'd0,
    CLS_ALU   = 3'd1,
    CLS_LOAD  = 3'd2,
    CLS_STORE = 3'd3,
    CLS_CTRL  = 3'd4,
    CLS_HALT  = 3'd5
  } cls_t;

endpackage

// File: rtl/op_classifier.sv
// Pure combinational opcode/funct -> instruction class. HALT_OP is checked
// first so a configured halt opcode always overrides the normal tables.
module op_classifier
  import cpu_pkg::*;
#(
  parameter logic [5:0] HALT_OP = 6'b111110
) (
  input  logic [5:0] opecode,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic       link
);

  // Class lookup; anything unrecognised retires as a NOP.
  always_comb begin
    cls = CLS_NOP;
    if (opecode == HALT_OP) begin
      cls = CLS_HALT;
    end else begin
      case (opecode)
        OP_LW:                                   cls = CLS_LOAD;
        OP_SW:                                   cls = CLS_STORE;
        OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_CTRL_X: cls = CLS_CTRL;
        OP_RTYPE: cls = (funct == OP_JR_FUNCT) ? CLS_CTRL : CLS_ALU;
        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:       cls = CLS_ALU;
        default:                                 cls = CLS_NOP;
      endcase
    end
    link = (cls == CLS_CTRL) && (opecode == OP_JAL);
  end

endmodule

// File: rtl/cycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer. Owns timing only: memory
// handshakes, commit strobes, memory watchdog and retired-instruction count.
// Outputs are combinational decodes of state and acks, forced low in reset.
module cycle_sequencer
  import cpu_pkg::*;
#(
  parameter int         TIMEOUT = 64,
  parameter logic [5:0] HALT_OP = 6'b111110,
  parameter int         CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opecode,
  input  logic [5:0]       funct,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             write_pc,
  output logic             write_reg,
  output logic             write_lr,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state_dbg,
  output logic [CNT_W-1:0] retired
);

  state_t      state, next;
  cls_t        cls;
  logic        link;
  logic [31:0] wait_cnt;
  logic        waiting, acked, expire;

  op_classifier #(.HALT_OP(HALT_OP)) u_cls (
    .opecode (opecode),
    .funct   (funct),
    .cls     (cls),
    .link    (link)
  );

  // Only the ack matching the current request state counts.
  assign waiting = (state == ST_FETCH) || (state == ST_MEM);
  assign acked   = ((state == ST_FETCH) && imem_ack) || ((state == ST_MEM) && dmem_ack);
  // Last permitted wait cycle with no ack; an ack in this cycle wins.
  assign expire  = (TIMEOUT != 0) && waiting && !acked && (wait_cnt == 32'(TIMEOUT - 1));

  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FETCH;
    else     state <= next;
  end

  // Watchdog: counts unacknowledged request cycles, zero everywhere else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  wait_cnt <= '0;
    else if (waiting && !acked) wait_cnt <= wait_cnt + 32'd1;
    else                      wait_cnt <= '0;
  end

  // Retired count: one per write_pc pulse, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           retired <= '0;
    else if (write_pc) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Next-state and output decode.
  always_comb begin
    next      = state;
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    write_pc  = 1'b0;
    write_reg = 1'b0;
    write_lr  = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          next    = ST_DECODE;
        end else if (expire) begin
          next = ST_FAULT;
        end
      end
      ST_DECODE: next = ST_EXEC;
      ST_EXEC: begin
        case (cls)
          CLS_LOAD, CLS_STORE: next = ST_MEM;
          CLS_ALU:             next = ST_WB;
          CLS_HALT:            next = ST_HALT;
          default: begin
            write_pc = 1'b1;
            write_lr = link;
            next     = ST_FETCH;
          end
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == CLS_STORE);
        if (dmem_ack) begin
          if (cls == CLS_STORE) begin
            write_pc = 1'b1;
            next     = ST_FETCH;
          end else begin
            next = ST_WB;
          end
        end else if (expire) begin
          next = ST_FAULT;
        end
      end
      ST_WB: begin
        write_reg = 1'b1;
        write_pc  = 1'b1;
        next      = ST_FETCH;
      end
      ST_HALT:  halted = 1'b1;
      ST_FAULT: fault  = 1'b1;
      default:  next   = ST_FETCH;
    endcase
    // Reset holds every request and strobe low even though state sits in FETCH.
    if (rst) begin
      imem_req  = 1'b0;
      ir_load   = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      write_pc  = 1'b0;
      write_reg = 1'b0;
      write_lr  = 1'b0;
      halted    = 1'b0;
      fault     = 1'b0;
    end
  end

endmodule
